// File: rtl/bus_transfer_arbiter.sv
// Round-robin sequencer for the shared 16-bit register bus.
// One register-to-register move at a time: drive, latch, done.
module bus_transfer_arbiter #(
    parameter int N_REQ = 4,
    parameter int SEL_W = 3,
    localparam int N_REG = 2 ** SEL_W,
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*SEL_W-1:0] src_sel,
    input  logic [N_REQ*SEL_W-1:0] dst_sel,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [N_REG-1:0]       read_en,
    output logic [N_REG-1:0]       write_en,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_LATCH,
        S_DONE
    } state_t;

    state_t state, nxt_state;

    logic [PW-1:0]    ptr, nxt_ptr;
    logic [PW-1:0]    win_q, nxt_win;
    logic [SEL_W-1:0] src_q, nxt_src;
    logic [SEL_W-1:0] dst_q, nxt_dst;

    logic [SEL_W-1:0] src_arr [N_REQ];
    logic [SEL_W-1:0] dst_arr [N_REQ];

    logic          found;
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;

    logic [N_REQ-1:0] grant_n, done_n;
    logic [N_REG-1:0] read_n, write_n;
    logic             busy_n;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign src_arr[i] = src_sel[i*SEL_W +: SEL_W];
        assign dst_arr[i] = dst_sel[i*SEL_W +: SEL_W];
    end

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_ptr   = ptr;
        nxt_win   = win_q;
        nxt_src   = src_q;
        nxt_dst   = dst_q;
        unique case (state)
            S_IDLE: begin
                if (found) begin
                    nxt_state = S_DRIVE;
                    nxt_win   = pick;
                    nxt_src   = src_arr[pick];
                    nxt_dst   = dst_arr[pick];
                    nxt_ptr   = PW'((int'(pick) + 1) % N_REQ);
                end
            end
            S_DRIVE: nxt_state = S_LATCH;
            S_LATCH: nxt_state = S_DONE;
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered.
    always_comb begin
        grant_n = '0;
        done_n  = '0;
        read_n  = '0;
        write_n = '0;
        busy_n  = (nxt_state != S_IDLE);
        unique case (nxt_state)
            S_DRIVE: begin
                grant_n[nxt_win] = 1'b1;
                read_n[nxt_src]  = 1'b1;
            end
            S_LATCH: begin
                grant_n[nxt_win] = 1'b1;
                read_n[nxt_src]  = 1'b1;
                write_n[nxt_dst] = 1'b1;
            end
            S_DONE: begin
                grant_n[nxt_win] = 1'b1;
                done_n[nxt_win]  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            win_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            grant    <= '0;
            done     <= '0;
            read_en  <= '0;
            write_en <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= nxt_state;
            ptr      <= nxt_ptr;
            win_q    <= nxt_win;
            src_q    <= nxt_src;
            dst_q    <= nxt_dst;
            grant    <= grant_n;
            done     <= done_n;
            read_en  <= read_n;
            write_en <= write_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_bus_transfer_arbiter.sv
// Scoreboard bench for bus_transfer_arbiter with a transaction-level
// round-robin model and a behavioural register file on the bus.
module tb_bus_transfer_arbiter;

    localparam int N_REQ = 4;
    localparam int SEL_W = 3;
    localparam int N_REG = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*SEL_W-1:0] src_sel;
    logic [N_REQ*SEL_W-1:0] dst_sel;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic [N_REG-1:0]       read_en;
    logic [N_REG-1:0]       write_en;
    logic                   busy;

    bus_transfer_arbiter #(.N_REQ(N_REQ), .SEL_W(SEL_W)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .src_sel(src_sel),
        .dst_sel(dst_sel),
        .grant(grant),
        .done(done),
        .read_en(read_en),
        .write_en(write_en),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int src;
        int dst;
    } xfer_t;

    xfer_t       q[$];
    int          age = 0;
    int          mptr = 0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] regs[N_REG];
    logic [15:0] ref_regs[N_REG];

    function automatic int oh_idx(input logic [N_REG-1:0] v);
        for (int i = 0; i < N_REG; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Bus registers and the reference arbitration model, both at the edge.
    always @(posedge clk) begin
        if (write_en != 0 && read_en != 0)
            regs[oh_idx(write_en)] = regs[oh_idx(read_en)];
        if (reset) begin
            q.delete();
            age  = 0;
            mptr = 0;
        end else if (age == 0) begin
            if (req != 0) begin
                xfer_t t;
                t.w = -1;
                for (int k = 0; k < N_REQ; k++) begin
                    int c;
                    c = (mptr + k) % N_REQ;
                    if (t.w < 0 && req[c]) t.w = c;
                end
                t.src = int'(src_sel[t.w*SEL_W +: SEL_W]);
                t.dst = int'(dst_sel[t.w*SEL_W +: SEL_W]);
                q.push_back(t);
                mptr = (t.w + 1) % N_REQ;
                age  = 1;
            end
        end else begin
            age = (age == 3) ? 0 : age + 1;
        end
    end

    // Monitor: compare every output each cycle, retire on done.
    always @(negedge clk) begin
        logic [N_REQ-1:0] eg, ed;
        logic [N_REG-1:0] er, ew;
        logic             eb;
        eg = '0; ed = '0; er = '0; ew = '0; eb = 1'b0;
        if (age != 0 && q.size() > 0) begin
            eb = 1'b1;
            eg[q[0].w] = 1'b1;
            if (age <= 2) er[q[0].src] = 1'b1;
            if (age == 2) ew[q[0].dst] = 1'b1;
            if (age == 3) ed[q[0].w] = 1'b1;
        end
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(eb));
        chk("read_en", 32'(read_en), 32'(er));
        chk("write_en", 32'(write_en), 32'(ew));
        chk("done", 32'(done), 32'(ed));
        chk("read_onehot", 32'($countones(read_en) <= 1), 32'd1);
        if (done != 0 && q.size() == 0) begin
            chk("done_unexpected", 32'(done), 32'd0);
        end else if ((done != 0 || age == 3) && q.size() > 0) begin
            xfer_t t;
            t = q.pop_front();
            ref_regs[t.dst] = ref_regs[t.src];
            chk("reg_data", 32'(regs[t.dst]), 32'(ref_regs[t.dst]));
        end
    end

    task automatic set_sel(input int i, input int s, input int d);
        src_sel[i*SEL_W +: SEL_W] = SEL_W'(s);
        dst_sel[i*SEL_W +: SEL_W] = SEL_W'(d);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        chk("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done != 0) return;
        end
        chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < N_REG; i++) begin
            regs[i]     = 16'(i * 16'h1111 + 16'h0a05);
            ref_regs[i] = regs[i];
        end
        reset   = 1'b1;
        req     = 4'b1111;
        src_sel = '0;
        dst_sel = '0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        src_sel = 12'($urandom);
        dst_sel = 12'($urandom);
        repeat (24) @(negedge clk);
        req = '0;
        wait_idle();

        set_sel(1, 3, 5);
        req = 4'b0010;
        @(negedge clk);
        wait_done();
        chk("single_done", 32'(done), 32'h2);
        req = '0;
        wait_idle();

        set_sel(2, 1, 6);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        set_sel(2, 2, 4);
        wait_done();
        chk("committed_done", 32'(done), 32'h4);
        wait_idle();

        set_sel(0, 4, 2);
        req = 4'b0001;
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        @(negedge clk);
        chk("rst_mid", 32'({grant, done, read_en, write_en, busy}), 32'd0);
        reset = 1'b0;
        set_sel(3, 6, 1);
        set_sel(0, 5, 3);
        req = 4'b1001;
        @(negedge clk);
        chk("rst_prio", 32'(grant), 32'h1);
        wait_done();
        req = '0;
        wait_idle();

        set_sel(3, 7, 7);
        req = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        chk("self_read", 32'(read_en), 32'h80);
        chk("self_write", 32'(write_en), 32'h80);
        wait_done();
        chk("self_done", 32'(done), 32'h8);
        req = '0;
        wait_idle();

        repeat (400) begin
            req     = 4'($urandom);
            src_sel = 12'($urandom);
            dst_sel = 12'($urandom);
            @(negedge clk);
        end
        req = '0;
        wait_idle();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
